// File: rtl/cpu_wb_arbiter_if.sv
// cpu_wb_arbiter_if: valid/ready write-back request channel from one result producer (EX or LSU).
// Widths fall back to the core defaults when cpu_define.v has not already set them.
`ifndef CPU_XLEN
`define CPU_XLEN 32
`endif
`ifndef CPU_GREGIDX_WIDTH
`define CPU_GREGIDX_WIDTH 5
`endif
`ifndef CPU_GREG_COUNT
`define CPU_GREG_COUNT 32
`endif
interface cpu_wb_arbiter_if;
   logic                          valid;
   logic [`CPU_GREGIDX_WIDTH-1:0] idx;
   logic [`CPU_XLEN-1:0]          dat;
   logic                          ready;
   modport master (output valid, idx, dat, input ready);
   modport slave (input valid, idx, dat, output ready);
endinterface

// File: rtl/cpu_wb_arbiter.sv
// cpu_wb_arbiter: shares the register file write port between EX and LSU and tracks pending writes.
// Macro CPU_WB_RR_EN selects round-robin arbitration; otherwise LSU has fixed priority over EX.
`ifndef CPU_XLEN
`define CPU_XLEN 32
`endif
`ifndef CPU_GREGIDX_WIDTH
`define CPU_GREGIDX_WIDTH 5
`endif
`ifndef CPU_GREG_COUNT
`define CPU_GREG_COUNT 32
`endif
module cpu_wb_arbiter (
   input  logic                          clk,
   input  logic                          rst,
   cpu_wb_arbiter_if.slave               ex,
   cpu_wb_arbiter_if.slave               lsu,
   input  logic                          sb_set,
   input  logic [`CPU_GREGIDX_WIDTH-1:0] sb_set_idx,
   input  logic [`CPU_GREGIDX_WIDTH-1:0] rs1_qidx,
   input  logic [`CPU_GREGIDX_WIDTH-1:0] rs2_qidx,
   output logic                          rs1_busy,
   output logic                          rs2_busy,
   output logic                          rd_wen,
   output logic [`CPU_GREGIDX_WIDTH-1:0] rd_idx,
   output logic [`CPU_XLEN-1:0]          rd_dat
);
   localparam int N = `CPU_GREG_COUNT;
   logic                          ex_gnt;
   logic                          lsu_gnt;
   logic                          gnt;
   logic [`CPU_GREGIDX_WIDTH-1:0] gnt_idx;
   logic [`CPU_XLEN-1:0]          gnt_dat;
   logic [N-1:0]                  busy;
   logic [N-1:0]                  set_mask;
   logic [N-1:0]                  clr_mask;
`ifdef CPU_WB_RR_EN
   logic last_ex;
   always_ff @(posedge clk)
      if (rst) last_ex <= 1'b0;
      else if (gnt) last_ex <= ex_gnt;
   always_comb ex_gnt = !rst && ex.valid && (!lsu.valid || !last_ex);
`else
   always_comb ex_gnt = !rst && ex.valid && !lsu.valid;
`endif
   always_comb begin
      lsu_gnt   = !rst && lsu.valid && !ex_gnt;
      gnt       = ex_gnt || lsu_gnt;
      gnt_idx   = ex_gnt ? ex.idx : lsu.idx;
      gnt_dat   = ex_gnt ? ex.dat : lsu.dat;
      ex.ready  = ex_gnt;
      lsu.ready = lsu_gnt;
      set_mask  = sb_set ? N'(1) << sb_set_idx : '0;
      clr_mask  = rd_wen ? N'(1) << rd_idx : '0;
      rs1_busy  = busy[rs1_qidx];
      rs2_busy  = busy[rs2_qidx];
   end
   always_ff @(posedge clk)
      if (rst) begin
         rd_wen <= 1'b0;
         rd_idx <= '0;
         rd_dat <= '0;
      end else begin
         rd_wen <= gnt && gnt_idx != '0;
         if (gnt) begin
            rd_idx <= gnt_idx;
            rd_dat <= gnt_dat;
         end
      end
   // set is applied after clear so a newly issued producer keeps the register pending
   always_ff @(posedge clk)
      if (rst) busy <= '0;
      else busy <= ((busy & ~clr_mask) | set_mask) & ~N'(1);
endmodule

// File: tb/tb_cpu_wb_arbiter.sv
// tb_cpu_wb_arbiter: directed checks of grant, output stage, scoreboard and reset behaviour.
`ifndef CPU_XLEN
`define CPU_XLEN 32
`endif
`ifndef CPU_GREGIDX_WIDTH
`define CPU_GREGIDX_WIDTH 5
`endif
`ifndef CPU_GREG_COUNT
`define CPU_GREG_COUNT 32
`endif
module tb_cpu_wb_arbiter;
   logic                          clk = 1'b0;
   logic                          rst = 1'b1;
   logic                          sb_set = 1'b0;
   logic [`CPU_GREGIDX_WIDTH-1:0] sb_set_idx = '0;
   logic [`CPU_GREGIDX_WIDTH-1:0] rs1_qidx = '0;
   logic [`CPU_GREGIDX_WIDTH-1:0] rs2_qidx = '0;
   logic                          rs1_busy, rs2_busy, rd_wen;
   logic [`CPU_GREGIDX_WIDTH-1:0] rd_idx;
   logic [`CPU_XLEN-1:0]          rd_dat;
   int checks = 0;
   int errors = 0;
   bit first_ex;
   cpu_wb_arbiter_if ex ();
   cpu_wb_arbiter_if lsu ();
   cpu_wb_arbiter dut (
      .clk(clk), .rst(rst), .ex(ex), .lsu(lsu),
      .sb_set(sb_set), .sb_set_idx(sb_set_idx),
      .rs1_qidx(rs1_qidx), .rs2_qidx(rs2_qidx),
      .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
      .rd_wen(rd_wen), .rd_idx(rd_idx), .rd_dat(rd_dat)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   initial begin
`ifdef CPU_WB_RR_EN
      first_ex = 1'b1;
`else
      first_ex = 1'b0;
`endif
      ex.valid = 1'b0; ex.idx = '0; ex.dat = '0;
      lsu.valid = 1'b0; lsu.idx = '0; lsu.dat = '0;
      tick();
      ex.valid = 1'b1; lsu.valid = 1'b1;
      #1;
      check("ready_in_rst_ex", ex.ready, 0);
      check("ready_in_rst_lsu", lsu.ready, 0);
      tick();
      ex.valid = 1'b0; lsu.valid = 1'b0;
      check("rst_wen", rd_wen, 0);
      check("rst_idx", rd_idx, 0);
      check("rst_dat", rd_dat, 0);
      rs1_qidx = 5'd5;
      #1 check("rst_busy", rs1_busy, 0);
      rst = 1'b0;
      // lone EX write
      tick();
      ex.valid = 1'b1; ex.idx = 5'd5; ex.dat = 32'h1234;
      #1;
      check("a_ex_ready", ex.ready, 1);
      check("a_lsu_ready", lsu.ready, 0);
      tick();
      ex.valid = 1'b0;
      check("a_wen", rd_wen, 1);
      check("a_idx", rd_idx, 5);
      check("a_dat", rd_dat, 32'h1234);
      tick();
      check("a_wen_off", rd_wen, 0);
      check("a_idx_hold", rd_idx, 5);
      check("a_dat_hold", rd_dat, 32'h1234);
      // lone LSU write to x0: accepted, dropped, and points round-robin back at EX
      lsu.valid = 1'b1; lsu.idx = 5'd0; lsu.dat = 32'hdead;
      #1 check("z_lsu_ready", lsu.ready, 1);
      tick();
      lsu.valid = 1'b0;
      check("z_wen", rd_wen, 0);
      // conflict
      ex.valid = 1'b1; ex.idx = 5'd3; ex.dat = 32'haaaa;
      lsu.valid = 1'b1; lsu.idx = 5'd4; lsu.dat = 32'hbbbb;
      #1;
      check("b_ex_ready", ex.ready, first_ex);
      check("b_lsu_ready", lsu.ready, !first_ex);
      tick();
      if (first_ex) ex.valid = 1'b0; else lsu.valid = 1'b0;
      check("b1_wen", rd_wen, 1);
      check("b1_idx", rd_idx, first_ex ? 3 : 4);
      check("b1_dat", rd_dat, first_ex ? 32'haaaa : 32'hbbbb);
      #1;
      check("b2_ex_ready", ex.ready, !first_ex);
      check("b2_lsu_ready", lsu.ready, first_ex);
      tick();
      ex.valid = 1'b0; lsu.valid = 1'b0;
      check("b2_wen", rd_wen, 1);
      check("b2_idx", rd_idx, first_ex ? 4 : 3);
      check("b2_dat", rd_dat, first_ex ? 32'hbbbb : 32'haaaa);
      // scoreboard set then clear through a write
      sb_set = 1'b1; sb_set_idx = 5'd7; rs1_qidx = 5'd7;
      #1 check("c_busy_before", rs1_busy, 0);
      tick();
      sb_set = 1'b0;
      check("c_busy_set", rs1_busy, 1);
      ex.valid = 1'b1; ex.idx = 5'd7; ex.dat = 32'h77;
      tick();
      ex.valid = 1'b0;
      check("c_wen", rd_wen, 1);
      check("c_busy_wen_cycle", rs1_busy, 1);
      tick();
      check("c_busy_cleared", rs1_busy, 0);
      // set and clear of the same index on one edge, plus a different index cleared
      sb_set = 1'b1; sb_set_idx = 5'd10;
      tick();
      sb_set_idx = 5'd7;
      tick();
      sb_set = 1'b0;
      ex.valid = 1'b1; ex.idx = 5'd7; ex.dat = 32'h70;
      tick();
      ex.valid = 1'b0;
      sb_set = 1'b1; sb_set_idx = 5'd7;
      tick();
      sb_set = 1'b0;
      #1 check("d_set_wins", rs1_busy, 1);
      ex.valid = 1'b1; ex.idx = 5'd10; ex.dat = 32'ha0;
      rs2_qidx = 5'd10;
      tick();
      ex.valid = 1'b0;
      sb_set = 1'b1; sb_set_idx = 5'd11;
      tick();
      sb_set = 1'b0;
      check("d_clr_10", rs2_busy, 0);
      rs2_qidx = 5'd11;
      #1 check("d_set_11", rs2_busy, 1);
      sb_set = 1'b1; sb_set_idx = 5'd0;
      tick();
      sb_set = 1'b0; rs2_qidx = 5'd0;
      #1 check("d_x0_busy", rs2_busy, 0);
      // EX write to x0
      ex.valid = 1'b1; ex.idx = 5'd0; ex.dat = 32'h55;
      #1 check("e_ex_ready", ex.ready, 1);
      tick();
      ex.valid = 1'b0;
      check("e_wen", rd_wen, 0);
      check("e_busy7_kept", rs1_busy, 1);
      // reset during the write-back cycle
      sb_set = 1'b1; sb_set_idx = 5'd9;
      tick();
      sb_set = 1'b0; rs2_qidx = 5'd9;
      #1 check("f_busy9", rs2_busy, 1);
      ex.valid = 1'b1; ex.idx = 5'd9; ex.dat = 32'h99;
      tick();
      ex.valid = 1'b0;
      check("f_wen", rd_wen, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("f_wen_rst", rd_wen, 0);
      check("f_dat_rst", rd_dat, 0);
      check("f_busy9_rst", rs2_busy, 0);
      check("f_busy7_rst", rs1_busy, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
